// File: rtl/seg_pkg.sv
// Segment pattern constants and width helpers for the 7-segment scan driver.
// Pure declarations, no latency; no backpressure.
package seg_pkg;

    typedef logic [6:0] seg_width_t;

    // Bit 0 = segment a ... bit 6 = segment g
    localparam seg_width_t SEG_BLANK = 7'h00;
    localparam seg_width_t SEG_DASH  = 7'h40;
    localparam seg_width_t SEG_0     = 7'h3F;
    localparam seg_width_t SEG_1     = 7'h06;
    localparam seg_width_t SEG_2     = 7'h5B;
    localparam seg_width_t SEG_3     = 7'h4F;
    localparam seg_width_t SEG_4     = 7'h66;
    localparam seg_width_t SEG_5     = 7'h6D;
    localparam seg_width_t SEG_6     = 7'h7D;
    localparam seg_width_t SEG_7     = 7'h07;
    localparam seg_width_t SEG_8     = 7'h7F;
    localparam seg_width_t SEG_9     = 7'h6F;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit-code input and segment/digit-select output bundle of the scan driver.
// Wires only, no latency; no backpressure (data_valid is a fire-and-forget strobe).
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    data_valid;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_start;
  logic                    pending;

  modport master (
    output data, dp, data_valid, blink_mask,
    input  seg, digit_sel, frame_start, pending
  );

  modport slave (
    input  data, dp, data_valid, blink_mask,
    output seg, digit_sel, frame_start, pending
  );
endinterface

// File: rtl/bcd_to_seg.sv
// 4-bit digit code to a..g pattern: 0-9 digits, 10-14 dash, 15 blank.
// Combinational, zero latency; no backpressure.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output seg_width_t pattern
);
  always_comb begin
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      4'd15:   pattern = SEG_BLANK;
      default: pattern = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment driver, tear-free frame-boundary commit, blink; optional SEG_LZ_BLANK_EN.
// Outputs registered 1 cycle after the scan index; no backpressure (last data_valid strobe wins).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input logic             clk,
  input logic             rst,
  seg_scan_driver_if.slave bus
);
  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int PRE_W = clog2_min1(SCAN_DIV);
  localparam int FRM_W = clog2_min1(BLINK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        idx;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    phase_on;
  logic                    last_boundary;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   digit_sel_q;
  logic                    frame_start_q;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            cur_code;
  seg_width_t            cur_pattern;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [7:0]            seg_next;

  assign tick     = (prescaler == LAST_PRE);
  assign boundary = tick && (idx == LAST_IDX);
  assign cur_code = disp_data[4*int'(idx) +: 4];

  bcd_to_seg u_bcd_to_seg (
    .code    (cur_code),
    .pattern (cur_pattern)
  );

`ifdef SEG_LZ_BLANK_EN
  logic lz_lead;

  // A digit is blanked only while every more-significant digit is also a plain zero
  always_comb begin
    lz_lead  = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_lead     = lz_lead && (disp_data[4*k +: 4] == 4'd0) && !disp_dp[k];
      lz_blank[k] = lz_lead;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    seg_next = {cur_pattern, disp_dp[idx]};
    if (lz_blank[idx] || (!phase_on && bus.blink_mask[idx])) begin
      seg_next = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler     <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      phase_on      <= 1'b1;
      last_boundary <= 1'b0;
      pending       <= 1'b0;
      shadow_data   <= '0;
      shadow_dp     <= '0;
      disp_data     <= '0;
      disp_dp       <= '0;
      seg_q         <= 8'h00;
      digit_sel_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      prescaler     <= tick ? '0 : prescaler + 1'b1;
      last_boundary <= boundary;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end

      if (bus.data_valid) begin
        shadow_data <= bus.data;
        shadow_dp   <= bus.dp;
      end
      // A strobe landing on the boundary bypasses the shadow so it is not held a whole frame
      if (boundary && bus.data_valid) begin
        disp_data <= bus.data;
        disp_dp   <= bus.dp;
        pending   <= 1'b0;
      end else if (boundary && pending) begin
        disp_data <= shadow_data;
        disp_dp   <= shadow_dp;
        pending   <= 1'b0;
      end else if (bus.data_valid) begin
        pending <= 1'b1;
      end

      if (boundary) begin
        if (frame_cnt == LAST_FRM) begin
          frame_cnt <= '0;
          phase_on  <= !phase_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      seg_q         <= seg_next;
      digit_sel_q   <= NUM_DIGITS'(1) << idx;
      frame_start_q <= last_boundary;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.digit_sel   = digit_sel_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
// Inputs driven and outputs sampled on the falling edge; cyc counts falling edges since reset release.
module tb_seg_scan_driver;
  localparam int ND = 4;

`ifdef SEG_LZ_BLANK_EN
  localparam int LZ0 = 'h00;
`else
  localparam int LZ0 = 'h7E;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (4),
    .BLINK_DIV  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic strobe(input logic [15:0] d, input logic [3:0] p);
    bus.data       = d;
    bus.dp         = p;
    bus.data_valid = 1'b1;
    @(negedge clk);
    cyc++;
    bus.data_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input int sel, input int seg);
    check({tag, "_sel"}, 32'(bus.digit_sel), 32'(sel));
    check({tag, "_seg"}, 32'(bus.seg), 32'(seg));
  endtask

  initial begin
    rst            = 1'b1;
    bus.data       = '0;
    bus.dp         = '0;
    bus.data_valid = 1'b0;
    bus.blink_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(bus.seg), 'h00);
    check("rst_sel", 32'(bus.digit_sel), 'h0);
    check("rst_fs", 32'(bus.frame_start), 'h0);
    check("rst_pend", 32'(bus.pending), 'h0);

    // Scan walk, first commit of 1234 at the frame boundary
    rst = 1'b0;
    cyc = 0;
    strobe(16'h1234, 4'b0000);
    check_out("t1_c1", 'h1, 'h7E);
    check("t1_c1_fs", 32'(bus.frame_start), 'h0);
    check("t1_c1_pend", 32'(bus.pending), 'h1);
    to_cyc(5);  check("t1_sel1", 32'(bus.digit_sel), 'h2);
    to_cyc(9);  check("t1_sel2", 32'(bus.digit_sel), 'h4);
    to_cyc(13); check_out("t1_d3_old", 'h8, LZ0);
    to_cyc(15); check("t1_pend15", 32'(bus.pending), 'h1);
    to_cyc(16); check("t1_pend16", 32'(bus.pending), 'h0);
    check("t1_fs16", 32'(bus.frame_start), 'h0);
    to_cyc(17); check_out("t1_d0", 'h1, 'hCC);
    check("t1_fs17", 32'(bus.frame_start), 'h1);
    to_cyc(18); check("t1_fs18", 32'(bus.frame_start), 'h0);
    to_cyc(21); check_out("t1_d1", 'h2, 'h9E);
    to_cyc(25); check_out("t1_d2", 'h4, 'hB6);
    to_cyc(29); check_out("t1_d3", 'h8, 'h0C);
    to_cyc(33); check("t1_fs33", 32'(bus.frame_start), 'h1);

    // Two strobes in one frame: last wins
    to_cyc(36); strobe(16'h5678, 4'b0000);
    check("t2_pend37", 32'(bus.pending), 'h1);
    to_cyc(40); strobe(16'h9ABC, 4'b0000);
    to_cyc(46); check("t2_pend46", 32'(bus.pending), 'h1);
    to_cyc(48); check("t2_pend48", 32'(bus.pending), 'h0);
    to_cyc(49); check_out("t2_d0", 'h1, 'h80);
    to_cyc(53); check_out("t2_d1", 'h2, 'h80);
    to_cyc(61); check_out("t2_d3", 'h8, 'hDE);

    // Strobe exactly in the boundary cycle
    to_cyc(63); strobe(16'h0F00, 4'b0000);
    check("t3_pend64", 32'(bus.pending), 'h0);
    to_cyc(65); check_out("t3_d0", 'h1, 'h7E);

    // Blink digit 1; 8888 committed at boundary 79
    to_cyc(66);
    bus.blink_mask = 4'b0010;
    strobe(16'h8888, 4'b0010);
    check("t4_pend67", 32'(bus.pending), 'h1);
    to_cyc(69);  check_out("t3_d1", 'h2, 'h7E);
    to_cyc(73);  check_out("t3_d2", 'h4, 'h00);
    to_cyc(81);  check_out("t4_d0_on", 'h1, 'hFE);
    to_cyc(85);  check_out("t4_d1_on", 'h2, 'hFF);
    to_cyc(89);  check_out("t4_d2_on", 'h4, 'hFE);
    to_cyc(97);  check_out("t4_d0_off", 'h1, 'hFE);
    to_cyc(101); check_out("t4_d1_off", 'h2, 'h00);
    to_cyc(117); check_out("t4_d1_off2", 'h2, 'h00);
    to_cyc(133); check_out("t4_d1_on2", 'h2, 'hFF);

    // Leading zeros (blanked only when SEG_LZ_BLANK_EN is defined)
    to_cyc(134);
    bus.blink_mask = 4'b0000;
    strobe(16'h0007, 4'b0000);
    to_cyc(145); check_out("t5_d0", 'h1, 'h0E);
    to_cyc(149); check_out("t5_d1", 'h2, LZ0);
    to_cyc(150); strobe(16'h0007, 4'b0100);
    to_cyc(153); check_out("t5_d2", 'h4, LZ0);
    to_cyc(157); check_out("t5_d3", 'h8, LZ0);
    to_cyc(161); check_out("t5_dp_d0", 'h1, 'h0E);
    to_cyc(165); check_out("t5_dp_d1", 'h2, 'h7E);
    to_cyc(169); check_out("t5_dp_d2", 'h4, 'h7F);
    to_cyc(173); check_out("t5_dp_d3", 'h8, LZ0);

    // Asynchronous reset mid-frame with a pending update
    to_cyc(180); strobe(16'h1234, 4'b0000);
    check("t6_pend", 32'(bus.pending), 'h1);
    to_cyc(184); check("t6_sel_pre", 32'(bus.digit_sel), 'h2);
    #2 rst = 1'b1;
    #1;
    check("t6_async_seg", 32'(bus.seg), 'h00);
    check("t6_async_sel", 32'(bus.digit_sel), 'h0);
    check("t6_async_fs", 32'(bus.frame_start), 'h0);
    check("t6_async_pend", 32'(bus.pending), 'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    to_cyc(1);  check_out("t6_d0", 'h1, 'h7E);
    to_cyc(16); check("t6_pend16", 32'(bus.pending), 'h0);
    to_cyc(17); check_out("t6_d0_nocommit", 'h1, 'h7E);
    check("t6_fs17", 32'(bus.frame_start), 'h1);
    to_cyc(29); check_out("t6_d3_nocommit", 'h8, LZ0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
